// File: rtl/snake_pkg.sv
// Shared types and IR command words for the snake game.
package snake_pkg;

   typedef enum logic [1:0] {
      START = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      END   = 2'd3
   } screen_t;

   // NEC words from the LG-style remote
   localparam logic [31:0] IR_UP    = 32'h20DF02FD;
   localparam logic [31:0] IR_DOWN  = 32'h20DF827D;
   localparam logic [31:0] IR_LEFT  = 32'h20DFE01F;
   localparam logic [31:0] IR_RIGHT = 32'h20DF609F;
   localparam logic [31:0] IR_ENTER = 32'h20DF5AA5;
   localparam logic [31:0] IR_MENU  = 32'h20DFC23D;

endpackage

// File: rtl/frame_buffer.sv
// Back/front frame buffers: one row captured per enabled clock, whole frame
// committed to the front buffer on the last row so the display never tears.
module frame_buffer #(
   parameter  int GRID_W = 16,
   parameter  int GRID_H = 16,
   localparam int ROW_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     scan_en,
   input  logic [GRID_W-1:0]        row_data,
   output logic [ROW_W-1:0]         row_idx,
   output logic [GRID_H*GRID_W-1:0] front,
   output logic                     swap
);

   logic [GRID_W-1:0] back [GRID_H];
   logic              last_row;

   assign last_row = (row_idx == ROW_W'(GRID_H - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_idx <= '0;
         front   <= '0;
         swap    <= 1'b0;
         for (int unsigned r = 0; r < GRID_H; r++) back[r] <= '0;
      end else if (clear) begin
         row_idx <= '0;
         front   <= '0;
         swap    <= 1'b0;
         for (int unsigned r = 0; r < GRID_H; r++) back[r] <= '0;
      end else begin
         swap <= 1'b0;
         if (scan_en) begin
            back[row_idx] <= row_data;
            if (last_row) begin
               row_idx <= '0;
               swap    <= 1'b1;
               // last row bypasses the back buffer; row 0 lands in the MSBs
               for (int unsigned r = 0; r < GRID_H; r++)
                  front[(GRID_H-1-r)*GRID_W +: GRID_W] <=
                     (r == unsigned'(GRID_H - 1)) ? row_data : back[r];
            end else begin
               row_idx <= row_idx + ROW_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/screen_ctrl.sv
// Screen/mode controller: START/PLAY/PAUSE/END FSM driven by IR commands,
// END-screen lockout, score tracking and the image mux to MatrixDisplay.
module screen_ctrl
   import snake_pkg::*;
#(
   parameter  int                         GRID_W      = 16,
   parameter  int                         GRID_H      = 16,
   parameter  int                         LEN_W       = 8,
   parameter  int                         SCORE_W     = 12,
   parameter  int                         SCORE_MUL   = 5,
   parameter  int                         HOLD_CYCLES = 50_000_000,
   parameter  logic [31:0]                CMD_ENTER   = IR_ENTER,
   parameter  logic [31:0]                CMD_MENU    = IR_MENU,
   parameter  logic [GRID_H*GRID_W-1:0]   START_IMG   = '1,
   parameter  logic [GRID_H*GRID_W-1:0]   END_IMG     = '0,
   localparam int                         ROW_W       = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [31:0]              ir_word,
   input  logic                     ir_valid,
   input  logic                     game_over,
   input  logic [LEN_W-1:0]         length,
   input  logic [GRID_W-1:0]        row_data,
   output logic [ROW_W-1:0]         row_idx,
   output logic [GRID_H*GRID_W-1:0] disp_grid,
   output logic                     frame_swap,
   output logic                     game_enable,
   output logic                     game_rst,
   output logic [1:0]               screen,
   output logic [SCORE_W-1:0]       score,
   output logic [SCORE_W-1:0]       high_score
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int PROD_W = LEN_W + SCORE_W;

   screen_t                  state, state_nxt;
   logic                     enter, menu, clear;
   logic [HOLD_W-1:0]        hold;
   logic [PROD_W-1:0]        prod;
   logic [SCORE_W-1:0]       score_sat;
   logic [GRID_H*GRID_W-1:0] front;

   assign enter = ir_valid && (ir_word == CMD_ENTER);
   assign menu  = ir_valid && (ir_word == CMD_MENU);

   always_comb begin
      state_nxt = state;
      unique case (state)
         START: if (enter) state_nxt = PLAY;
         PLAY: begin
            if (game_over)  state_nxt = END;
            else if (menu)  state_nxt = PAUSE;
         end
         PAUSE: if (enter || menu) state_nxt = PLAY;
         END:   if (enter && (hold == '0)) state_nxt = START;
         default: state_nxt = START;
      endcase
   end

   assign clear = (state == START) && (state_nxt == PLAY);

   assign prod      = PROD_W'(length) * PROD_W'(SCORE_MUL);
   assign score_sat = (prod > PROD_W'({SCORE_W{1'b1}})) ? '1 : prod[SCORE_W-1:0];

   frame_buffer #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_frame_buffer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .scan_en  (state == PLAY),
      .row_data (row_data),
      .row_idx  (row_idx),
      .front    (front),
      .swap     (frame_swap)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= START;
         hold       <= '0;
         score      <= '0;
         high_score <= '0;
         game_rst   <= 1'b0;
         disp_grid  <= '0;
      end else begin
         state    <= state_nxt;
         game_rst <= clear;
         if ((state == PLAY) && (state_nxt == END)) begin
            score <= score_sat;
            if (score_sat > high_score) high_score <= score_sat;
            hold  <= HOLD_W'(HOLD_CYCLES - 1);
         end else if ((state == END) && (hold != '0)) begin
            hold <= hold - HOLD_W'(1);
         end
         case (state)
            START:   disp_grid <= START_IMG;
            END:     disp_grid <= END_IMG;
            default: disp_grid <= front;
         endcase
      end
   end

   assign game_enable = (state == PLAY);
   assign screen      = state;

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl with an expectation queue for frame swaps
// and game_rst pulses, checked by independent monitor processes.
module tb_screen_ctrl;
   import snake_pkg::*;

   localparam int W    = 16;
   localparam int H    = 16;
   localparam int HOLD = 100;
   localparam logic [H*W-1:0] S_IMG = {16{16'hA5C3}};
   localparam logic [H*W-1:0] E_IMG = {16{16'h3C5A}};
   localparam logic [H*W-1:0] DIAG  = {16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                       16'h0010, 16'h0020, 16'h0040, 16'h0080,
                                       16'h0100, 16'h0200, 16'h0400, 16'h0800,
                                       16'h1000, 16'h2000, 16'h4000, 16'h8000};

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [31:0]    ir_word;
   logic           ir_valid;
   logic           game_over;
   logic [7:0]     length;
   logic [W-1:0]   row_data, row_data6;
   logic [3:0]     row_idx, row_idx6;
   logic [H*W-1:0] disp_grid, disp6;
   logic           frame_swap, swap6, game_enable, en6, game_rst, rst6;
   logic [1:0]     screen, screen6;
   logic [11:0]    score, high_score;
   logic [5:0]     score6, high6;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {int at; logic [H*W-1:0] frame;} frame_exp_t;
   frame_exp_t fq[$];
   int         rq[$];

   always #5 clk = ~clk;

   assign row_data  = 16'h0001 << row_idx;
   assign row_data6 = 16'h0001 << row_idx6;

   screen_ctrl #(.GRID_W(W), .GRID_H(H), .LEN_W(8), .SCORE_W(12), .SCORE_MUL(5),
                 .HOLD_CYCLES(HOLD), .START_IMG(S_IMG), .END_IMG(E_IMG)) dut (
      .clk(clk), .reset_n(reset_n), .ir_word(ir_word), .ir_valid(ir_valid),
      .game_over(game_over), .length(length), .row_data(row_data), .row_idx(row_idx),
      .disp_grid(disp_grid), .frame_swap(frame_swap), .game_enable(game_enable),
      .game_rst(game_rst), .screen(screen), .score(score), .high_score(high_score));

   screen_ctrl #(.GRID_W(W), .GRID_H(H), .LEN_W(8), .SCORE_W(6), .SCORE_MUL(5),
                 .HOLD_CYCLES(HOLD), .START_IMG(S_IMG), .END_IMG(E_IMG)) dut6 (
      .clk(clk), .reset_n(reset_n), .ir_word(ir_word), .ir_valid(ir_valid),
      .game_over(game_over), .length(length), .row_data(row_data6), .row_idx(row_idx6),
      .disp_grid(disp6), .frame_swap(swap6), .game_enable(en6),
      .game_rst(rst6), .screen(screen6), .score(score6), .high_score(high6));

   always @(posedge clk) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic send(input logic [31:0] w);
      ir_word  = w;
      ir_valid = 1'b1;
      tick();
      ir_valid = 1'b0;
      ir_word  = '0;
   endtask

   // game_rst monitor: each pulse must match the next expected cycle
   always @(negedge clk) begin : rst_mon
      int e;
      if (reset_n && game_rst) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL game_rst: unexpected pulse at cycle %0d", cyc);
         end else begin
            e = rq.pop_front();
            if (e != cyc) begin
               errors++;
               $display("FAIL game_rst: pulse at cycle %0d, expected cycle %0d", cyc, e);
            end
         end
      end
   end

   // frame monitor: swap cycle, then the displayed frame one cycle later
   initial begin : frame_mon
      frame_exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && frame_swap) begin
            checks++;
            if (fq.size() == 0) begin
               errors++;
               $display("FAIL frame_swap: unexpected pulse at cycle %0d", cyc);
            end else begin
               e = fq.pop_front();
               if (e.at != cyc) begin
                  errors++;
                  $display("FAIL frame_swap: pulse at cycle %0d, expected cycle %0d", cyc, e.at);
               end
               @(negedge clk);
               checks++;
               if (disp_grid !== e.frame) begin
                  errors++;
                  $display("FAIL frame: got %0h, expected %0h (cycle %0d)", disp_grid, e.frame, cyc);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      ir_word   = '0;
      ir_valid  = 1'b0;
      game_over = 1'b0;
      length    = 8'd9;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      chk("rst_screen", screen, START);
      chk("rst_disp", disp_grid, '0);
      chk("rst_outs", {score, high_score, row_idx, frame_swap, game_enable, game_rst}, '0);
      chk("rst_outs6", {disp6, score6, high6, screen6, row_idx6, swap6, en6, rst6}, '0);
      go_to(2);
      chk("start_img", disp_grid, S_IMG);

      fq.push_back('{27, DIAG});
      fq.push_back('{43, DIAG});
      fq.push_back('{79, DIAG});
      fq.push_back('{95, DIAG});
      rq.push_back(11);

      go_to(5);
      send(IR_UP);
      ir_word = IR_ENTER;                 // level without ir_valid
      tick();
      ir_word = '0;
      go_to(9);
      chk("ignore_cmds", screen, START);

      go_to(10);
      send(IR_ENTER);
      chk("enter_play", screen, PLAY);
      chk("play_enable", game_enable, 1'b1);
      chk("play_row0", row_idx, 4'd0);
      tick();
      chk("cleared_front", disp_grid, '0);
      chk("game_rst_low", game_rst, 1'b0);

      go_to(20);
      send(IR_ENTER);
      chk("play_ignores_enter", screen, PLAY);

      go_to(50);
      send(IR_MENU);
      chk("pause", screen, PAUSE);
      chk("pause_enable", game_enable, 1'b0);
      chk("pause_row", row_idx, 4'd8);
      go_to(70);
      chk("pause_row_held", row_idx, 4'd8);
      chk("pause_frozen", disp_grid, DIAG);
      send(IR_MENU);
      chk("resume", screen, PLAY);
      chk("resume_row", row_idx, 4'd8);
      tick();
      chk("resume_row_next", row_idx, 4'd9);

      go_to(100);
      game_over = 1'b1;
      send(IR_MENU);
      game_over = 1'b0;
      chk("over_priority", screen, END);
      chk("score", score, 12'd45);
      chk("high", high_score, 12'd45);
      chk("score6", score6, 6'd45);
      chk("end_enable", game_enable, 1'b0);
      tick();
      chk("end_img", disp_grid, E_IMG);

      go_to(151);
      send(IR_ENTER);
      chk("hold_ignore_50", screen, END);
      go_to(199);
      send(IR_ENTER);
      chk("hold_ignore_last", screen, END);
      go_to(202);
      send(IR_ENTER);
      chk("hold_release", screen, START);
      tick();
      chk("start_img_again", disp_grid, S_IMG);

      length = 8'd20;
      rq.push_back(211);
      go_to(210);
      send(IR_ENTER);
      chk("play2", screen, PLAY);
      tick();
      chk("cleared_front2", disp_grid, '0);
      go_to(220);
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      chk("end2", screen, END);
      chk("score2", score, 12'd100);
      chk("high2", high_score, 12'd100);
      chk("score6_sat", score6, 6'd63);
      chk("high6_sat", high6, 6'd63);

      go_to(322);
      send(IR_ENTER);
      chk("start3", screen, START);
      rq.push_back(326);
      go_to(325);
      send(IR_ENTER);
      go_to(333);
      chk("scan3_row", row_idx, 4'd7);
      #2 reset_n = 1'b0;
      #1;
      chk("async_screen", screen, START);
      chk("async_disp", disp_grid, '0);
      chk("async_outs", {score, high_score, row_idx, frame_swap, game_enable, game_rst}, '0);
      chk("async_outs6", {disp6, score6, high6, screen6, row_idx6, swap6, en6, rst6}, '0);

      chk("frames_left", fq.size(), 0);
      chk("rsts_left", rq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
